// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between NUM_REQ writeback sources.
// Optional macro REGWR_X0_DROP_EN: writes to register 0 are accepted but never asserted on RegWrite.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       wr_hold,
  output logic                       RegWrite,
  output logic [ADDR_W-1:0]          Write_register,
  output logic [DATA_W-1:0]          Write_data,
  input  logic [ADDR_W-1:0]          chk_addr,
  output logic                       chk_pending
);

  localparam int PW = $clog2(NUM_REQ);
  localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);

  logic [ADDR_W-1:0] w_addr [NUM_REQ];
  logic [DATA_W-1:0] w_data [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_addr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign w_data[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  logic [PW-1:0]     r_ptr;
  logic              r_regwrite;
  logic [ADDR_W-1:0] r_wreg;
  logic [DATA_W-1:0] r_wdata;

  logic              w_found;
  logic [PW-1:0]     w_gidx;
  logic [PW:0]       w_idx;
  logic              w_xfer;
  logic              w_stage_we;
  logic [PW-1:0]     w_ptr_next;
  logic [ADDR_W-1:0] w_gaddr;
  logic [DATA_W-1:0] w_gdata;

  // Search upward from the pointer; one extra bit keeps ptr+k from overflowing before the wrap.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(NUM_REQ))
        w_idx = w_idx - (PW+1)'(NUM_REQ);
      if (!w_found && req_valid[w_idx[PW-1:0]]) begin
        w_found = 1'b1;
        w_gidx  = w_idx[PW-1:0];
      end
    end
    if (wr_hold)
      w_found = 1'b0;
  end

  assign w_xfer     = w_found & ~rst;
  assign req_ready  = w_xfer ? (NUM_REQ'(1) << w_gidx) : '0;
  assign w_gaddr    = w_addr[w_gidx];
  assign w_gdata    = w_data[w_gidx];
  assign w_ptr_next = (w_gidx == LAST) ? '0 : w_gidx + PW'(1);

`ifdef REGWR_X0_DROP_EN
  assign w_stage_we = w_xfer & (w_gaddr != '0);
`else
  assign w_stage_we = w_xfer;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= '0;
      r_regwrite <= 1'b0;
      r_wreg     <= '0;
      r_wdata    <= '0;
    end else begin
      r_regwrite <= w_stage_we;
      if (w_xfer) begin
        r_ptr   <= w_ptr_next;
        r_wreg  <= w_gaddr;
        r_wdata <= w_gdata;
      end
    end
  end

  assign RegWrite       = r_regwrite;
  assign Write_register = r_wreg;
  assign Write_data     = r_wdata;

`ifdef REGWR_X0_DROP_EN
  assign chk_pending = r_regwrite & (r_wreg == chk_addr) & (chk_addr != '0);
`else
  assign chk_pending = r_regwrite & (r_wreg == chk_addr);
`endif

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the register file's single write port (RegWrite / Write_register / Write_data) between NUM_REQ writeback sources, e.g. ALU writeback and load writeback.
- Arbitration: round-robin with a valid/ready handshake per requester.
- Output: the winning write is registered and driven to the register file one cycle later.
- Hazard support: a pending-write lookup lets decode detect a read of a register whose write has not yet landed.

Parameters:
NUM_REQ, 2, number of writeback requesters (2..8)
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-requester write request
req_addr  input  NUM_REQ*ADDR_W  packed destination register, requester i at [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  packed write data, requester i at [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
wr_hold  input  1  suspends arbitration (no grants) while high
RegWrite  output  1  write enable to register file
Write_register  output  ADDR_W  destination register to register file
Write_data  output  DATA_W  write data to register file
chk_addr  input  ADDR_W  register address to test for a pending write
chk_pending  output  1  staged write targets chk_addr

Behaviour:
- Reset (async, rst=1):
  - RegWrite=0, Write_register=0, Write_data=0.
  - Round-robin pointer=0 (requester 0 highest priority).
  - Any staged write is discarded and never reaches the register file.
  - req_ready=0 while rst is high.
- Arbitration (combinational each cycle):
  - If wr_hold=0, grant the first valid requester searching from ptr upward, modulo NUM_REQ.
  - req_ready is one-hot for the winner and all-zero if none is valid.
  - req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
  - Requesters hold req_valid, req_addr and req_data stable until accepted.
- Pointer update: on an accepted transfer from requester g, ptr <= (g+1) mod NUM_REQ. Otherwise ptr is unchanged.
- Output stage, on each rising edge:
  - With a transfer: RegWrite<=1 and Write_register/Write_data <= the granted requester's addr/data.
  - Without a transfer: RegWrite<=0; Write_register/Write_data hold their previous values.
  - The register file always accepts, so the stage drains every cycle and there is no backpressure from the file.
- Latency:
  - Request accepted at edge N.
  - RegWrite high during cycle N..N+1.
  - Register file updated at edge N+1.
  - Throughput is one write per cycle.
- Fairness: a requester holding req_valid is granted within NUM_REQ cycles while wr_hold=0.
- wr_hold:
  - Takes effect in the same cycle: req_ready=0.
  - A write already staged still completes (RegWrite stays 1 for that one cycle).
- chk_pending = RegWrite & (Write_register == chk_addr). This covers a combinational read in the same cycle as the staged write, which would otherwise return stale data.
- Simultaneous requests to the same address from different requesters are serialized in grant order; the last granted value wins.

Optional Feature:
- Macro: REGWR_X0_DROP_EN.
- Defined:
  - A granted request with addr==0 is accepted (req_ready asserted, pointer advances).
  - RegWrite is forced to 0 for that staged cycle.
  - chk_pending is never asserted for chk_addr==0.
- Undefined: writes to address 0 are issued like any other.

Test Plan:
- Assert rst mid-stream with RegWrite=1 (addr 7, data 0xDEAD) -> RegWrite=0 immediately; register 7 unchanged after next edge.
- Req0 only: addr 3, data 0x11AB0 -> req_ready=01; RegWrite=1, Write_register=3, Write_data=0x11AB0 the next cycle; register 3 reads 0x11AB0 after the following edge.
- Req0 and req1 valid continuously, with distinct data, for 6 cycles -> grants alternate 0,1,0,1,0,1 starting from requester 0 after reset; one write per cycle.
- Both requests target addr 5 (req0 0x10, req1 0x20), ptr=0 -> register 5 ends at 0x20.
- wr_hold=1 for 3 cycles with both valid -> req_ready=00 and RegWrite=0 from the second hold cycle onward; on release, the grant resumes at the pointer position.
- chk_addr=4 while the staged write targets 4 -> chk_pending=1; chk_addr=4 while the staged write targets 2 -> chk_pending=0.
- With REGWR_X0_DROP_EN defined, req addr 0 -> accepted; RegWrite stays 0.
